// File: rtl/fp_add_ctrl.sv
// fp_add_ctrl: multi-cycle sequencer for the shared FP adder.
// Holds operands for EXEC_CYCLES, captures, writes back, keeps fflags.
module fp_add_ctrl #(
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op_sub,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_addr,
  input  logic        flush,
  input  logic        fflags_clr,
  output logic        busy,
  output logic        done,
  output logic        rd_we,
  output logic [4:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_result,
  input  logic        add_overflow,
  input  logic        add_underflow,
  output logic [1:0]  fflags
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] cnt;
  logic       accept;
  logic       capture;

  assign accept  = (state == S_IDLE) && start && !flush;
  assign capture = (state == S_EXEC) && (cnt == 4'd0) && !flush;

  // Next-state selection; flush always drops back to IDLE
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == S_IDLE: if (accept) state_nxt = S_EXEC;
      state == S_EXEC: begin
        if (flush)
          state_nxt = S_IDLE;
        else if (cnt == 4'd0)
          state_nxt = S_WB;
      end
      state == S_WB: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State plus flopped decodes so busy/done/rd_we come straight off flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      rd_we <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_WB);
      rd_we <= (state_nxt == S_WB);
    end
  end

  // Operand/destination latch on issue and multicycle hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a    <= '0;
      add_b    <= '0;
      rd_waddr <= '0;
      cnt      <= '0;
    end else if (accept) begin
      add_a    <= rs1_val;
      add_b    <= {rs2_val[31] ^ op_sub, rs2_val[30:0]};
      rd_waddr <= rd_addr;
      cnt      <= CNT_INIT;
    end else if (state == S_EXEC && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Result capture at the end of the hold window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_wdata <= '0;
    else if (capture)
      rd_wdata <= add_result;
  end

  // Sticky flags; a clear coinciding with capture keeps only new flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fflags <= '0;
    else if (capture)
      fflags <= (fflags_clr ? 2'b00 : fflags)
              | {add_overflow, add_underflow};
    else if (fflags_clr)
      fflags <= '0;
  end

endmodule

// File: tb/tb_fp_add_ctrl.sv
// tb_fp_add_ctrl: directed + randomized bench for fp_add_ctrl.
// Two instances: EXEC_CYCLES=2 (dut0) and EXEC_CYCLES=1 (dut1).
module tb_fp_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_addr = '0;
  logic        flush = 1'b0;
  logic        fflags_clr = 1'b0;
  logic [31:0] add_result = '0;
  logic        add_overflow = 1'b0;
  logic        add_underflow = 1'b0;

  logic        busy0, done0, we0, busy1, done1, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1, a0, a1, b0, b1;
  logic [1:0]  ff0, ff1;

  logic        o_busy, o_done, o_we;
  logic [4:0]  o_wa;
  logic [31:0] o_wd, o_a, o_b;
  logic [1:0]  o_ff;

  int          n_vec = 0;
  int          n_err = 0;
  logic        sel_q = 1'b0;
  logic [1:0]  exp_ff = 2'b00;

  always #5 clk = ~clk;

  fp_add_ctrl #(.EXEC_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
    .flush(flush), .fflags_clr(fflags_clr),
    .busy(busy0), .done(done0), .rd_we(we0),
    .rd_waddr(wa0), .rd_wdata(wd0), .add_a(a0), .add_b(b0),
    .add_result(add_result), .add_overflow(add_overflow),
    .add_underflow(add_underflow), .fflags(ff0)
  );

  fp_add_ctrl #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
    .flush(flush), .fflags_clr(fflags_clr),
    .busy(busy1), .done(done1), .rd_we(we1),
    .rd_waddr(wa1), .rd_wdata(wd1), .add_a(a1), .add_b(b1),
    .add_result(add_result), .add_overflow(add_overflow),
    .add_underflow(add_underflow), .fflags(ff1)
  );

  always_comb begin
    o_busy = sel_q ? busy1 : busy0;
    o_done = sel_q ? done1 : done0;
    o_we   = sel_q ? we1 : we0;
    o_wa   = sel_q ? wa1 : wa0;
    o_wd   = sel_q ? wd1 : wd0;
    o_a    = sel_q ? a1 : a0;
    o_b    = sel_q ? b1 : b0;
    o_ff   = sel_q ? ff1 : ff0;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, o_busy, 0);
    chk({tag, " done"}, o_done, 0);
    chk({tag, " rd_we"}, o_we, 0);
    chk({tag, " rd_waddr"}, o_wa, 0);
    chk({tag, " rd_wdata"}, o_wd, 0);
    chk({tag, " add_a"}, o_a, 0);
    chk({tag, " add_b"}, o_b, 0);
    chk({tag, " fflags"}, o_ff, 0);
  endtask

  // Scrambles everything the DUT should be ignoring this cycle
  task automatic junk_in();
    rs1_val       = $urandom;
    rs2_val       = $urandom;
    op_sub        = 1'($urandom);
    rd_addr       = 5'($urandom);
    add_result    = $urandom;
    add_overflow  = 1'b1;
    add_underflow = 1'b1;
  endtask

  // One operation; fph = EXEC phase (1..e) carrying flush, 0 = none
  task automatic run_op(input logic sel, input int e,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [4:0] rd,
                        input logic [31:0] res, input logic ov,
                        input logic uf, input int fph, input logic clr);
    logic [31:0] eb;
    bit gone;
    sel_q = sel;
    eb = {b[31] ^ sub, b[30:0]};
    gone = 0;
    @(negedge clk);
    junk_in();
    start = 1'b1; rs1_val = a; rs2_val = b; op_sub = sub;
    rd_addr = rd; flush = 1'b0; fflags_clr = 1'b0;
    for (int p = 1; p <= e + 1 && !gone; p++) begin
      @(negedge clk);
      chk("op busy", o_busy, 1);
      chk("op done", o_done, 32'(p == e + 1));
      chk("op rd_we", o_we, 32'(p == e + 1));
      chk("op add_a", o_a, a);
      chk("op add_b", o_b, eb);
      if (p == e + 1) begin
        chk("wb rd_waddr", o_wa, 32'(rd));
        chk("wb rd_wdata", o_wd, res);
        chk("wb fflags", o_ff, 32'(exp_ff));
      end
      junk_in();
      start = 1'b0;
      fflags_clr = 1'b0;
      flush = (p == fph);
      if (p == e) begin
        add_result = res;
        add_overflow = ov;
        add_underflow = uf;
        fflags_clr = clr;
        if (p == fph) begin
          if (clr) exp_ff = 2'b00;
        end else begin
          exp_ff = (clr ? 2'b00 : exp_ff) | {ov, uf};
        end
      end
      if (p == fph) gone = 1;
    end
    @(negedge clk);
    chk("idle busy", o_busy, 0);
    chk("idle done", o_done, 0);
    chk("idle rd_we", o_we, 0);
    chk("idle fflags", o_ff, 32'(exp_ff));
    chk("idle add_a", o_a, a);
    chk("idle add_b", o_b, eb);
    start = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
    if (gone) begin
      start = 1'b1; flush = 1'b1; rs1_val = $urandom;
      @(negedge clk);
      chk("flush+start busy", o_busy, 0);
      chk("flush+start add_a", o_a, a);
      start = 1'b0; flush = 1'b0;
    end
  endtask

  initial begin
    int la;
    logic [31:0] ea, eb;
    logic [4:0]  erd;
    logic [31:0] rh [0:31];
    logic        ov, uf, sb;

    #1;
    sel_q = 1'b0; chk_zero("reset0");
    sel_q = 1'b1; chk_zero("reset1");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // add pass-through and subtract sign flip
    run_op(0, 2, 32'h3F80_0000, 32'h4000_0000, 0, 5'd5,
           32'h4040_0000, 0, 0, 0, 0);
    run_op(0, 2, 32'h4040_0000, 32'h3F80_0000, 1, 5'd9,
           32'h4000_0000, 0, 0, 0, 0);
    run_op(0, 2, $urandom, $urandom, 0, 5'd0, $urandom, 0, 0, 0, 0);

    // sticky flags
    run_op(0, 2, $urandom, $urandom, 0, 5'd1, $urandom, 1, 0, 0, 0);
    run_op(0, 2, $urandom, $urandom, 1, 5'd2, $urandom, 0, 0, 0, 0);
    chk("sticky OF", o_ff, 32'h2);
    @(negedge clk);
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    exp_ff = 2'b00;
    chk("clr alone", o_ff, 32'(exp_ff));
    run_op(0, 2, $urandom, $urandom, 0, 5'd3, $urandom, 1, 0, 0, 0);
    run_op(0, 2, $urandom, $urandom, 0, 5'd4, $urandom, 0, 1, 0, 1);
    chk("clr on capture", o_ff, 32'h1);

    // flush in first EXEC cycle, then on the capture edge
    run_op(0, 2, $urandom, $urandom, 0, 5'd6, $urandom, 1, 1, 1, 0);
    run_op(0, 2, $urandom, $urandom, 1, 5'd7, $urandom, 1, 1, 2, 0);
    run_op(0, 2, $urandom, $urandom, 0, 5'd8, $urandom, 0, 0, 0, 0);

    // randomized operations
    for (int i = 0; i < 8; i++) begin
      ov = ($urandom_range(0, 3) == 0);
      uf = ($urandom_range(0, 3) == 0);
      sb = 1'($urandom);
      run_op(0, 2, $urandom, $urandom, sb, 5'($urandom),
             $urandom, ov, uf, 0, 1'($urandom_range(0, 4) == 0));
    end

    // start held high: accepts only from IDLE, every EXEC_CYCLES+2
    sel_q = 1'b0;
    la = -100;
    ea = '0; eb = '0; erd = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("stream busy", o_busy, 32'((c > la) && (c <= la + 3)));
      chk("stream done", o_done, 32'(c == la + 3));
      if (la >= 0 && c > la) begin
        chk("stream add_a", o_a, ea);
        chk("stream add_b", o_b, eb);
      end
      if (c == la + 3) begin
        chk("stream rd_wdata", o_wd, rh[la + 2]);
        chk("stream rd_waddr", o_wa, 32'(erd));
      end
      rs1_val = $urandom; rs2_val = $urandom;
      op_sub = 1'($urandom); rd_addr = 5'($urandom);
      add_result = $urandom;
      add_overflow = 1'b0; add_underflow = 1'b0;
      start = 1'b1; flush = 1'b0; fflags_clr = 1'b0;
      rh[c] = add_result;
      if (c >= la + 4) begin
        la = c;
        ea = rs1_val;
        eb = {rs2_val[31] ^ op_sub, rs2_val[30:0]};
        erd = rd_addr;
      end
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("stream fflags", o_ff, 32'(exp_ff));

    // async reset mid-EXEC, not aligned to a clock edge
    @(negedge clk);
    start = 1'b1; rs1_val = $urandom; rs2_val = $urandom;
    @(negedge clk);
    start = 1'b0;
    chk("pre-reset busy", o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    sel_q = 1'b0; chk_zero("async0");
    sel_q = 1'b1; chk_zero("async1");
    @(negedge clk);
    rst_n = 1'b1;
    exp_ff = 2'b00;
    sel_q = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post-reset done", o_done, 0);
      chk("post-reset rd_we", o_we, 0);
      chk("post-reset busy", o_busy, 0);
    end

    // EXEC_CYCLES = 1 instance
    run_op(1, 1, 32'h3F80_0000, 32'h4000_0000, 0, 5'd5,
           32'h4040_0000, 0, 0, 0, 0);
    run_op(1, 1, $urandom, $urandom, 1, 5'd17, $urandom, 0, 1, 0, 0);
    run_op(1, 1, $urandom, $urandom, 0, 5'd18, $urandom, 1, 0, 1, 0);
    run_op(1, 1, $urandom, $urandom, 1, 5'd19, $urandom, 1, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
